// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bundle between the fetch sequencer and imem.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives PC update controls, runs the imem req/ack handshake,
// buffers one fetched instruction for IF/ID and squashes fetches on redirect.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [63:0]        pc_cur,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic [63:0]        pc_load_val,
  fetch_sequencer_if.master  imem,
  input  logic               redirect,
  input  logic [63:0]        redir_target,
  input  logic               stall,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [63:0]        if_pc,
  output logic               fetch_fault
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, FAULT} state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_INC  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b10;

  state_t      state;
  logic [15:0] wait_cnt;
  logic        pend_flag;
  logic [63:0] pend_target;
  logic        timeout_hit;

  assign timeout_hit    = (ACK_TIMEOUT != 0) && (wait_cnt == 16'(ACK_TIMEOUT - 1));
  assign imem.imem_addr = pc_cur;

  // All PC and request controls are forced idle while reset is held.
  always_comb begin
    imem.imem_req = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = SEL_HOLD;
    pc_load_val   = '0;
    if (!reset) begin
      case (state)
        BOOT: begin
          pc_we       = 1'b1;
          pc_sel      = SEL_LOAD;
          pc_load_val = RESET_PC;
        end
        FETCH: begin
          if (redirect) begin
            pc_we       = 1'b1;
            pc_sel      = SEL_LOAD;
            pc_load_val = redir_target;
          end else if (!(if_valid && stall)) begin
            imem.imem_req = 1'b1;
          end
        end
        WAIT: begin
          imem.imem_req = 1'b1;
          if (imem.imem_ack) begin
            pc_we = 1'b1;
            if (redirect) begin
              pc_sel      = SEL_LOAD;
              pc_load_val = redir_target;
            end else if (pend_flag) begin
              pc_sel      = SEL_LOAD;
              pc_load_val = pend_target;
            end else begin
              pc_sel = SEL_INC;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A redirect seen while waiting is remembered so the returning word is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      wait_cnt    <= '0;
      pend_flag   <= 1'b0;
      pend_target <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            if_valid <= 1'b0;
          end else if (!(if_valid && stall)) begin
            if_valid <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            if (!(redirect || pend_flag)) begin
              if_valid <= 1'b1;
              if_instr <= imem.imem_rdata;
              if_pc    <= pc_cur;
            end
            pend_flag <= 1'b0;
            state     <= FETCH;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (redirect) begin
              pend_target <= redir_target;
              pend_flag   <= 1'b1;
            end
            if (timeout_hit) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end
          end
        end
        FAULT: if_valid <= 1'b0;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table for the handshake corner cases,
// then randomized traffic scored against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] IW      = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc_cur = 64'hDEAD_0000_0000_BEEF;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [63:0] pc_load_val;
  logic        redirect = 1'b0;
  logic [63:0] redir_target = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        fetch_fault;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(.RESET_PC(64'h0), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_cur),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .pc_load_val  (pc_load_val),
    .imem         (imem_bus),
    .redirect     (redirect),
    .redir_target (redir_target),
    .stall        (stall),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  // Stand-in for the PC datapath: the only place PC+4 happens.
  always @(posedge clk) begin
    if (pc_we && pc_sel == 2'b01)      pc_cur <= pc_cur + 64'd4;
    else if (pc_we && pc_sel == 2'b10) pc_cur <= pc_load_val;
  end

  typedef struct {
    logic        st;
    logic        rd;
    logic [63:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_we;
    logic [1:0]  e_sel;
    logic [63:0] e_load;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic st, input logic rd, input logic [63:0] tgt,
                        input logic ack, input logic [31:0] rdata,
                        input logic e_req, input logic [63:0] e_addr,
                        input logic e_we, input logic [1:0] e_sel, input logic [63:0] e_load,
                        input logic e_valid, input logic [63:0] e_pc, input logic [31:0] e_instr,
                        input logic e_fault);
    vec_t v;
    v.st = st; v.rd = rd; v.tgt = tgt; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_sel = e_sel; v.e_load = e_load;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr; v.e_fault = e_fault;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic [63:0] tgt, input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    reset                = rst;
    stall                = st;
    redirect             = rd;
    redir_target         = tgt;
    imem_bus.imem_ack    = ack;
    imem_bus.imem_rdata  = rdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d_req", idx), 64'(imem_bus.imem_req), 64'(v.e_req));
    if (v.e_req) checkOutput($sformatf("vec%0d_addr", idx), imem_bus.imem_addr, v.e_addr);
    checkOutput($sformatf("vec%0d_we", idx), 64'(pc_we), 64'(v.e_we));
    if (v.e_we) checkOutput($sformatf("vec%0d_sel", idx), 64'(pc_sel), 64'(v.e_sel));
    if (v.e_we && v.e_sel == 2'b10) checkOutput($sformatf("vec%0d_load", idx), pc_load_val, v.e_load);
    checkOutput($sformatf("vec%0d_valid", idx), 64'(if_valid), 64'(v.e_valid));
    if (v.e_valid) begin
      checkOutput($sformatf("vec%0d_ifpc", idx), if_pc, v.e_pc);
      checkOutput($sformatf("vec%0d_instr", idx), 64'(if_instr), 64'(v.e_instr));
    end
    checkOutput($sformatf("vec%0d_fault", idx), 64'(fetch_fault), 64'(v.e_fault));
  endtask

  task automatic checkBoot(input string tag);
    checkOutput({tag, "_req"}, 64'(imem_bus.imem_req), 64'd0);
    checkOutput({tag, "_we"}, 64'(pc_we), 64'd1);
    checkOutput({tag, "_sel"}, 64'(pc_sel), 64'd2);
    checkOutput({tag, "_load"}, pc_load_val, 64'h0);
    checkOutput({tag, "_valid"}, 64'(if_valid), 64'd0);
    checkOutput({tag, "_fault"}, 64'(fetch_fault), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        was_busy, out_busy, out_squash, ack, st, rd, exp_req, squash_now;
    logic [63:0] out_addr, out_target, tgt, tgt_now, m_pc, m_next;
    logic [31:0] out_data, m_instr;
    logic        m_valid;
    int          out_delay, out_age;

    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rst_req", 64'(imem_bus.imem_req), 64'd0);
    checkOutput("rst_we", 64'(pc_we), 64'd0);
    checkOutput("rst_sel", 64'(pc_sel), 64'd0);
    checkOutput("rst_valid", 64'(if_valid), 64'd0);
    checkOutput("rst_ifpc", if_pc, 64'h0);
    checkOutput("rst_instr", 64'(if_instr), 64'h0);
    checkOutput("rst_fault", 64'(fetch_fault), 64'd0);

    // Boot, steady fetch, stall hold, pending and same-cycle redirects, timeout.
    addVec(0,0,0,0,0,        0,0,     1,2'b10,0,     0,0,0,0);
    addVec(0,0,0,0,0,        1,0,     0,0,0,         0,0,0,0);
    addVec(0,0,0,1,IW+0,     1,0,     1,2'b01,0,     0,0,0,0);
    addVec(0,0,0,0,0,        1,4,     0,0,0,         1,0,IW+0,0);
    addVec(0,0,0,1,IW+1,     1,4,     1,2'b01,0,     0,0,0,0);
    addVec(0,0,0,0,0,        1,8,     0,0,0,         1,4,IW+1,0);
    addVec(0,0,0,1,IW+2,     1,8,     1,2'b01,0,     0,0,0,0);
    for (int k = 0; k < 5; k++)
      addVec(1,0,0,0,0,      0,0,     0,0,0,         1,8,IW+2,0);
    addVec(0,0,0,0,0,        1,12,    0,0,0,         1,8,IW+2,0);
    addVec(0,0,0,1,IW+3,     1,12,    1,2'b01,0,     0,0,0,0);
    addVec(0,0,0,0,0,        1,16,    0,0,0,         1,12,IW+3,0);
    addVec(0,1,64'h400,0,0,  1,16,    0,0,0,         0,0,0,0);
    addVec(0,0,0,0,0,        1,16,    0,0,0,         0,0,0,0);
    addVec(0,0,0,0,0,        1,16,    0,0,0,         0,0,0,0);
    addVec(0,0,0,1,IW+4,     1,16,    1,2'b10,64'h400, 0,0,0,0);
    addVec(0,0,0,0,0,        1,64'h400, 0,0,0,       0,0,0,0);
    addVec(0,1,64'h200,1,IW+5, 1,64'h400, 1,2'b10,64'h200, 0,0,0,0);
    addVec(0,0,0,0,0,        1,64'h200, 0,0,0,       0,0,0,0);
    addVec(0,1,64'h100,0,0,  1,64'h200, 0,0,0,       0,0,0,0);
    addVec(0,1,64'h300,0,0,  1,64'h200, 0,0,0,       0,0,0,0);
    addVec(0,0,0,1,IW+6,     1,64'h200, 1,2'b10,64'h300, 0,0,0,0);
    addVec(0,0,0,0,0,        1,64'h300, 0,0,0,       0,0,0,0);
    addVec(0,0,0,1,IW+7,     1,64'h300, 1,2'b01,0,   0,0,0,0);
    addVec(0,0,0,0,0,        1,64'h304, 0,0,0,       1,64'h300,IW+7,0);
    addVec(0,0,0,1,IW+8,     1,64'h304, 1,2'b01,0,   0,0,0,0);
    addVec(1,1,64'h500,0,0,  0,0,     1,2'b10,64'h500, 1,64'h304,IW+8,0);
    addVec(0,0,0,0,0,        1,64'h500, 0,0,0,       0,0,0,0);
    for (int k = 0; k < 4; k++)
      addVec(0,0,0,0,0,      1,64'h500, 0,0,0,       0,0,0,0);
    addVec(0,0,0,0,0,        0,0,     0,0,0,         0,0,0,1);
    addVec(0,1,64'h600,0,0,  0,0,     0,0,0,         0,0,0,1);
    addVec(0,0,0,1,IW+9,     0,0,     0,0,0,         0,0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].st, vecs[i].rd, vecs[i].tgt, vecs[i].ack, vecs[i].rdata);
      checkVec(i, vecs[i]);
    end

    // Only reset leaves FAULT.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkBoot("fault_rst");

    // Reset while waiting, with a late ack the following cycle.
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rw_req0", 64'(imem_bus.imem_req), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, IW+10);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rw_addr4", imem_bus.imem_addr, 64'h4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, IW+11);
    checkBoot("rw_boot");
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rw_valid", 64'(if_valid), 64'd0);
    checkOutput("rw_req", 64'(imem_bus.imem_req), 64'd1);
    checkOutput("rw_addr0", imem_bus.imem_addr, 64'h0);

    // Randomized traffic against a model of the expected fetch stream.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkBoot("rnd_boot");
    out_busy = 0; out_squash = 0; out_addr = '0; out_target = '0; out_data = '0;
    out_delay = 1; out_age = 0;
    m_valid = 0; m_pc = '0; m_instr = '0; m_next = 64'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      st  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 6) == 0);
      tgt = 64'($urandom_range(0, 1023)) << 2;
      was_busy = out_busy;
      ack = out_busy && (out_age == out_delay);
      applyStimulus(0, st, rd, tgt, ack, ack ? out_data : $urandom);

      exp_req = was_busy || (!rd && !(m_valid && st));
      checkOutput("rnd_req", 64'(imem_bus.imem_req), 64'(exp_req));
      checkOutput("rnd_valid", 64'(if_valid), 64'(m_valid));
      if (m_valid) begin
        checkOutput("rnd_ifpc", if_pc, m_pc);
        checkOutput("rnd_instr", 64'(if_instr), 64'(m_instr));
      end
      checkOutput("rnd_fault", 64'(fetch_fault), 64'd0);

      if (was_busy && ack) begin
        squash_now = out_squash || rd;
        tgt_now    = rd ? tgt : out_target;
        checkOutput("rnd_ack_we", 64'(pc_we), 64'd1);
        checkOutput("rnd_ack_sel", 64'(pc_sel), squash_now ? 64'd2 : 64'd1);
        if (squash_now) begin
          checkOutput("rnd_ack_load", pc_load_val, tgt_now);
          m_valid = 0;
          m_next  = tgt_now;
        end else begin
          m_valid = 1;
          m_pc    = out_addr;
          m_instr = out_data;
          m_next  = out_addr + 64'd4;
        end
        out_busy   = 0;
        out_squash = 0;
      end else if (was_busy) begin
        checkOutput("rnd_wait_we", 64'(pc_we), 64'd0);
        out_age++;
        if (rd) begin
          out_squash = 1;
          out_target = tgt;
        end
      end else if (rd) begin
        checkOutput("rnd_redir_we", 64'(pc_we), 64'd1);
        checkOutput("rnd_redir_sel", 64'(pc_sel), 64'd2);
        checkOutput("rnd_redir_load", pc_load_val, tgt);
        m_valid = 0;
        m_next  = tgt;
      end else begin
        checkOutput("rnd_idle_we", 64'(pc_we), 64'd0);
        if (exp_req) begin
          checkOutput("rnd_addr", imem_bus.imem_addr, m_next);
          m_valid    = 0;
          out_busy   = 1;
          out_addr   = m_next;
          out_data   = $urandom;
          out_delay  = $urandom_range(1, TIMEOUT);
          out_age    = 1;
          out_squash = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
